div_seq_unit: RTL
=================

# div_seq_unit

Iterative, single-row restoring divider controller for unsigned operands with a normalized divisor. It accepts one division at a time over a valid/ready handshake and computes one quotient bit per cycle on a shared (widthY+1)-bit subtractor, sequencing partial remainders through an FSM. It returns Q = floor(X/Y) and R = X mod Y. It is the area-lean, multi-cycle counterpart of the fully combinational array dividers and sits between a requesting pipeline stage and its consumer.

## Interface
- widthX, default 16: dividend width.
- widthY, default 8: divisor and remainder width; widthY >= 2, widthX > widthY.
- widthQ, derived local: widthX-widthY+1, the quotient width and the number of iteration cycles.
- clk_i  in  1  clock; all state on rising edge.
- rst_ni  in  1  reset, asynchronous and active-low.
- in_valid_i  in  1  request valid.
- in_ready_o  out  1  block can accept a request this cycle.
- X_i  in  widthX  dividend, unsigned.
- Y_i  in  widthY  divisor, unsigned; must have Y_i[widthY-1]=1.
- flush_i  in  1  synchronous abort; any state goes to IDLE and the result is dropped.
- out_valid_o  out  1  result valid.
- out_ready_i  in  1  consumer accepts result.
- Q_o  out  widthQ  quotient.
- R_o  out  widthY  remainder.
- err_o  out  1  divisor was not normalized; qualified by out_valid_o.
- busy_o  out  1  high in BUSY.

## Operation
- States: IDLE, BUSY, DONE.
- in_ready_o = (state==IDLE) | (state==DONE & out_ready_i). This is a combinational path from out_ready_i and allows back-to-back operations.
- Accept = in_valid_i & in_ready_o & ~flush_i. On accept, X_i and Y_i are latched into internal registers.
- Accept with Y_i[widthY-1]=1:
  - Partial remainder P (widthY bits) = {1'b0, X_i[widthX-1:widthQ]}.
  - Step counter = widthQ-1; go to BUSY.
- Accept with Y_i[widthY-1]=0: go directly to DONE with Q_o = all ones, R_o = 0 and err_o = 1. No iterations run.
- Each BUSY cycle processes row k = counter:
  - D = {P, Xreg[k]}, widthY+1 bits.
  - T = D - {1'b0, Yreg}, computed widthY+2 bits wide.
  - If no borrow, q = 1 and P <= T[widthY-1:0]. Otherwise q = 0 and P <= D[widthY-1:0] (restore).
  - The quotient register shifts q in at the LSB.
  - Invariant P < Y always holds, so the widthY-bit truncation is lossless.
- When k==0: Q_o <= final quotient, R_o <= final P, err_o <= 0, then go to DONE.
- DONE: out_valid_o=1 and Q_o/R_o/err_o are held stable until out_ready_i.
  - On out_ready_i without a new accept, go to IDLE.
  - On out_ready_i with a new accept in the same cycle, start the new operation (BUSY, or DONE again for an error case).
- flush_i has priority over every transition and over accept. It forces IDLE, clears out_valid_o and leaves Q_o/R_o as they are.
- Q_o, R_o and err_o hold their last values outside DONE; they are meaningful only while out_valid_o=1.

## Timing
- Reset values: state IDLE, in_ready_o=1, out_valid_o=0, busy_o=0, Q_o=0, R_o=0, err_o=0, counter=0, P=0.
- Normal latency: the accept edge is E0; BUSY occupies E1..E(widthQ-1); the DONE-entry edge is EwidthQ. out_valid_o rises exactly widthQ cycles after the accept edge (9 for the defaults).
- Error latency: out_valid_o is high in the cycle immediately after the accept edge.
- Throughput with out_ready_i tied high: one result every widthQ cycles. in_ready_o is low throughout BUSY.
- Input changes during BUSY have no effect, because operands are latched at accept.
- Asynchronous reset during BUSY or DONE returns to reset values immediately. The in-flight result is lost and no out_valid_o is produced for it.
- flush_i asserted in the same cycle as out_ready_i in DONE: the result counts as discarded and no new request is accepted that cycle.

## Test plan
- X=0x1234, Y=0x80, out_ready_i=1 -> after 9 cycles out_valid_o=1, Q_o=0x024, R_o=0x34, err_o=0.
- X=0xFFFF, Y=0xFF -> Q_o=0x101, R_o=0x00. Then X=0xFFFF, Y=0x80 -> Q_o=0x1FF, R_o=0x7F (covers the maximum quotient and the all-restore and all-subtract paths).
- Y=0x7F, X=0x1234 -> out_valid_o one cycle after accept, err_o=1, Q_o=0x1FF, R_o=0x00, busy_o never high.
- Backpressure: hold out_ready_i=0 for 5 cycles in DONE -> outputs are stable and in_ready_o=0. Then raise out_ready_i together with a new valid request X=0x0100, Y=0x80 -> accepted in the same cycle, and the next result is Q_o=0x002, R_o=0x00.
- Drive rst_ni low at BUSY row 4 -> all outputs reach reset values asynchronously. After release, X=0x1234, Y=0x80 completes correctly (Q_o=0x024, R_o=0x34).
- flush_i at BUSY row 2 -> IDLE next cycle with no out_valid_o. flush_i together with in_valid_i in IDLE -> no accept.

Source files
------------

// File: rtl/div_seq_unit_if.sv
// Request/response bundle for the sequential restoring divider.
// Slave modport faces the divider, master modport faces the requester/consumer pair.
interface div_seq_unit_if #(
    parameter int unsigned widthX = 16,
    parameter int unsigned widthY = 8
);
    localparam int unsigned widthQ = widthX - widthY + 1;

    logic              in_valid_i;
    logic              in_ready_o;
    logic [widthX-1:0] X_i;
    logic [widthY-1:0] Y_i;
    logic              flush_i;
    logic              out_valid_o;
    logic              out_ready_i;
    logic [widthQ-1:0] Q_o;
    logic [widthY-1:0] R_o;
    logic              err_o;
    logic              busy_o;

    modport slave (
        input  in_valid_i, X_i, Y_i, flush_i, out_ready_i,
        output in_ready_o, out_valid_o, Q_o, R_o, err_o, busy_o
    );

    modport master (
        output in_valid_i, X_i, Y_i, flush_i, out_ready_i,
        input  in_ready_o, out_valid_o, Q_o, R_o, err_o, busy_o
    );
endinterface

// File: rtl/div_seq_unit.sv
// Iterative restoring divider for a normalized unsigned divisor: one quotient bit
// per cycle on a single (widthY+1)-bit subtractor, valid/ready in and out.
module div_seq_unit #(
    parameter int unsigned widthX = 16,
    parameter int unsigned widthY = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    div_seq_unit_if.slave    bus
);
    localparam int unsigned widthQ = widthX - widthY + 1;
    localparam int unsigned cnt_w  = (widthQ > 2) ? $clog2(widthQ) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

    state_e              state_q, state_d;
    logic                in_ready_c;
    logic                accept_c;
    logic                norm_c;
    logic                last_c;

    logic [widthQ-1:0]   xs_q;
    logic [widthY-1:0]   y_q;
    logic [widthY-1:0]   p_q;
    logic [cnt_w-1:0]    cnt_q;
    logic [widthQ-1:0]   quot_q;

    logic [widthQ-1:0]   q_q;
    logic [widthY-1:0]   r_q;
    logic                err_q;
    logic                out_valid_q;
    logic                busy_q;

    logic [widthY:0]     d_c;
    logic [widthY+1:0]   t_c;
    logic                bit_c;
    logic [widthY-1:0]   p_next_c;
    logic [widthQ-1:0]   quot_next_c;

    assign in_ready_c = (state_q == IDLE) | ((state_q == DONE) & bus.out_ready_i);
    assign accept_c   = bus.in_valid_i & in_ready_c & ~bus.flush_i;
    assign norm_c     = bus.Y_i[widthY-1];
    assign last_c     = (cnt_q == '0);

    // One restoring step; P < Y keeps bit widthY of T clear whenever there is no borrow.
    always_comb begin
        d_c         = {p_q, xs_q[widthQ-1]};
        t_c         = {1'b0, d_c} - {2'b00, y_q};
        bit_c       = ~|t_c[widthY+1:widthY];
        p_next_c    = bit_c ? t_c[widthY-1:0] : d_c[widthY-1:0];
        quot_next_c = {quot_q[widthQ-2:0], bit_c};
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state; flush overrides every transition including a same-cycle accept.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept_c) state_d = norm_c ? BUSY : DONE;
            BUSY: if (last_c) state_d = DONE;
            DONE: begin
                if (bus.out_ready_i) begin
                    if (accept_c) state_d = norm_c ? BUSY : DONE;
                    else          state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (bus.flush_i) state_d = IDLE;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            out_valid_q <= (state_d == DONE);
            busy_q      <= (state_d == BUSY);
        end
    end

    // Operand latch, iteration registers and result registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            xs_q   <= '0;
            y_q    <= '0;
            p_q    <= '0;
            cnt_q  <= '0;
            quot_q <= '0;
            q_q    <= '0;
            r_q    <= '0;
            err_q  <= 1'b0;
        end else if (!bus.flush_i) begin
            if (accept_c) begin
                xs_q <= bus.X_i[widthQ-1:0];
                y_q  <= bus.Y_i;
                if (norm_c) begin
                    p_q    <= {1'b0, bus.X_i[widthX-1:widthQ]};
                    cnt_q  <= cnt_w'(widthQ - 1);
                    quot_q <= '0;
                end else begin
                    q_q   <= '1;
                    r_q   <= '0;
                    err_q <= 1'b1;
                end
            end else if (state_q == BUSY) begin
                p_q    <= p_next_c;
                xs_q   <= {xs_q[widthQ-2:0], 1'b0};
                quot_q <= quot_next_c;
                cnt_q  <= cnt_q - cnt_w'(1);
                if (last_c) begin
                    q_q   <= quot_next_c;
                    r_q   <= p_next_c;
                    err_q <= 1'b0;
                end
            end
        end
    end

    assign bus.in_ready_o  = in_ready_c;
    assign bus.out_valid_o = out_valid_q;
    assign bus.busy_o      = busy_q;
    assign bus.Q_o         = q_q;
    assign bus.R_o         = r_q;
    assign bus.err_o       = err_q;
endmodule
